mul_div_unit: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage; executes the HI/LO-class `funct` codes produced by ID funct generation and owns the architectural HI and LO registers. Multiplies finish in 1–2 extra cycles; divides use a 32-iteration radix-2 restoring divider. While an operation is in flight it raises a stall request to the pipeline controller, and it commits HI/LO or the MUL GPR result in a single DONE cycle.

---
 rtl/mul_div_if.sv | 24 ++
 rtl/mul_div_unit.sv | 148 ++++++++++++++
 tb/tb_mul_div_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mul_div_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide unit.
// The pipeline side drives the operation; the unit returns stall, HI/LO and the MUL result.
interface mul_div_if;
  logic        flush;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mul_result;
  logic        result_valid;

  modport master (
    output flush, start, funct, op_a, op_b,
    input  stall_req, hi, lo, mul_result, result_valid
  );

  modport slave (
    input  flush, start, funct, op_a, op_b,
    output stall_req, hi, lo, mul_result, result_valid
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO: 1-2 cycle multiplies, MADD/MSUB
// accumulate, and a 32-iteration radix-2 restoring divider with sign fix-up.
module mul_div_unit (
  input  logic       clk,
  input  logic       rst,
  mul_div_if.slave   bus
);
  localparam logic [5:0] FUNCT_MTHI   = 6'h11;
  localparam logic [5:0] FUNCT_MTLO   = 6'h13;
  localparam logic [5:0] FUNCT_MULT   = 6'h18;
  localparam logic [5:0] FUNCT_MULTU  = 6'h19;
  localparam logic [5:0] FUNCT_DIV    = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU   = 6'h1b;
  localparam logic [5:0] FUNCT2_MADD  = 6'h38;
  localparam logic [5:0] FUNCT2_MADDU = 6'h39;
  localparam logic [5:0] FUNCT2_MUL   = 6'h3a;
  localparam logic [5:0] FUNCT2_MSUB  = 6'h3c;
  localparam logic [5:0] FUNCT2_MSUBU = 6'h3d;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_ACC  = 3'd2;
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]  state;
  logic [5:0]  op_q;
  logic [31:0] a_q;
  logic [63:0] res_q;
  logic [31:0] dvs_q, rem_q, quot_q;
  logic        neg_quo_q, neg_rem_q, dvz_q;
  logic [5:0]  cnt;

  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] x, input logic n);
    return n ? (32'd0 - x) : x;
  endfunction

  logic is_mthi, is_mtlo, is_mulc, is_madd, is_div, is_sgn, is_multi;
  assign is_mthi  = (bus.funct == FUNCT_MTHI);
  assign is_mtlo  = (bus.funct == FUNCT_MTLO);
  assign is_mulc  = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_MULTU) ||
                    (bus.funct == FUNCT2_MUL);
  assign is_madd  = (bus.funct == FUNCT2_MADD) || (bus.funct == FUNCT2_MADDU) ||
                    (bus.funct == FUNCT2_MSUB) || (bus.funct == FUNCT2_MSUBU);
  assign is_div   = (bus.funct == FUNCT_DIV) || (bus.funct == FUNCT_DIVU);
  assign is_sgn   = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT2_MUL) ||
                    (bus.funct == FUNCT2_MADD) || (bus.funct == FUNCT2_MSUB) ||
                    (bus.funct == FUNCT_DIV);
  assign is_multi = is_mulc || is_madd || is_div;

  // One 64x64 multiplier serves both signednesses: operands are sign- or zero-extended.
  logic signed [63:0] ax, bx, prod;
  assign ax   = {{32{is_sgn & bus.op_a[31]}}, bus.op_a};
  assign bx   = {{32{is_sgn & bus.op_b[31]}}, bus.op_b};
  assign prod = ax * bx;

  logic [63:0] hilo, acc;
  logic        acc_sub;
  assign hilo    = {bus.hi, bus.lo};
  assign acc_sub = (op_q == FUNCT2_MSUB) || (op_q == FUNCT2_MSUBU);
  assign acc     = acc_sub ? (hilo - res_q) : (hilo + res_q);

  // Restoring step: shift the next dividend bit into the partial remainder, keep the trial if non-negative.
  logic [32:0] shifted, diff;
  logic [31:0] rem_n, quot_n;
  logic [63:0] div_res;
  assign shifted = {rem_q, quot_q[31]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign rem_n   = diff[32] ? shifted[31:0] : diff[31:0];
  assign quot_n  = {quot_q[30:0], ~diff[32]};
  assign div_res = dvz_q ? {a_q, 32'hffff_ffff}
                         : {neg_if(rem_n, neg_rem_q), neg_if(quot_n, neg_quo_q)};

  assign bus.stall_req = rst && !bus.flush &&
                         ((state == S_IDLE && bus.start && is_multi) ||
                          state == S_MUL || state == S_ACC || state == S_DIV);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= S_IDLE;
      bus.hi           <= 32'd0;
      bus.lo           <= 32'd0;
      bus.mul_result   <= 32'd0;
      bus.result_valid <= 1'b0;
      cnt              <= 6'd0;
    end else begin
      bus.result_valid <= 1'b0;
      if (bus.flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (bus.start) begin
            if (is_mthi) bus.hi <= bus.op_a;
            if (is_mtlo) bus.lo <= bus.op_a;
            if (is_multi) begin
              op_q <= bus.funct;
              a_q  <= bus.op_a;
            end
            if (is_mulc) begin
              res_q <= prod;
              state <= S_DONE;
              if (bus.funct == FUNCT2_MUL) begin
                bus.mul_result   <= prod[31:0];
                bus.result_valid <= 1'b1;
              end
            end
            if (is_madd) begin
              res_q <= prod;
              state <= S_ACC;
            end
            if (is_div) begin
              dvs_q     <= mag(bus.op_b, is_sgn);
              quot_q    <= mag(bus.op_a, is_sgn);
              rem_q     <= 32'd0;
              neg_quo_q <= is_sgn && (bus.op_a[31] ^ bus.op_b[31]);
              neg_rem_q <= is_sgn && bus.op_a[31];
              dvz_q     <= (bus.op_b == 32'd0);
              cnt       <= 6'd0;
              state     <= S_DIV;
            end
          end
          S_ACC: begin
            res_q <= acc;
            state <= S_DONE;
          end
          S_DIV: begin
            rem_q  <= rem_n;
            quot_q <= quot_n;
            cnt    <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              res_q <= div_res;
              state <= S_DONE;
            end
          end
          S_DONE: begin
            if (op_q != FUNCT2_MUL) {bus.hi, bus.lo} <= res_q;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed cases plus random operations checked against
// an arithmetic HI/LO model.
module tb_mul_div_unit;
  localparam logic [5:0] FUNCT_MTHI   = 6'h11;
  localparam logic [5:0] FUNCT_MTLO   = 6'h13;
  localparam logic [5:0] FUNCT_MULT   = 6'h18;
  localparam logic [5:0] FUNCT_MULTU  = 6'h19;
  localparam logic [5:0] FUNCT_DIV    = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU   = 6'h1b;
  localparam logic [5:0] FUNCT2_MADD  = 6'h38;
  localparam logic [5:0] FUNCT2_MADDU = 6'h39;
  localparam logic [5:0] FUNCT2_MUL   = 6'h3a;
  localparam logic [5:0] FUNCT2_MSUB  = 6'h3c;
  localparam logic [5:0] FUNCT2_MSUBU = 6'h3d;
  localparam logic [5:0] FUNCT_ADD    = 6'h20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_div_if bus();
  mul_div_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int ncmp = 0;
  int nerr = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_mul = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int exp_stalls(input logic [5:0] f);
    case (f)
      FUNCT_MULT, FUNCT_MULTU, FUNCT2_MUL:                     return 1;
      FUNCT2_MADD, FUNCT2_MADDU, FUNCT2_MSUB, FUNCT2_MSUBU:   return 2;
      FUNCT_DIV, FUNCT_DIVU:                                   return 33;
      default:                                                 return 0;
    endcase
  endfunction

  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint la, lb;
    logic [63:0] sp, up, hl;
    ia = a; ib = b;
    la = longint'(ia); lb = longint'(ib);
    sp = la * lb;
    up = {32'd0, a} * {32'd0, b};
    hl = {m_hi, m_lo};
    case (f)
      FUNCT_MTHI:   m_hi = a;
      FUNCT_MTLO:   m_lo = a;
      FUNCT_MULT:   {m_hi, m_lo} = sp;
      FUNCT_MULTU:  {m_hi, m_lo} = up;
      FUNCT2_MUL:   m_mul = sp[31:0];
      FUNCT2_MADD:  {m_hi, m_lo} = hl + sp;
      FUNCT2_MADDU: {m_hi, m_lo} = hl + up;
      FUNCT2_MSUB:  {m_hi, m_lo} = hl - sp;
      FUNCT2_MSUBU: {m_hi, m_lo} = hl - up;
      FUNCT_DIVU: begin
        if (b == 32'd0) begin m_lo = 32'hffff_ffff; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      FUNCT_DIV: begin
        if (b == 32'd0) begin m_lo = 32'hffff_ffff; m_hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin m_lo = a; m_hi = 32'd0; end
        else begin m_lo = ia / ib; m_hi = ia % ib; end
      end
      default: ;
    endcase
  endtask

  // Issue one instruction at negedge+1 and hold it in EX until the unit releases it.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int st;
    bus.start = 1'b1; bus.funct = f; bus.op_a = a; bus.op_b = b;
    #1;
    st = 0;
    while (bus.stall_req === 1'b1 && st < 100) begin
      st++;
      @(negedge clk); #2;
    end
    check($sformatf("stalls f=%h", f), 64'(st), 64'(exp_stalls(f)));
    model(f, a, b);
    if (f == FUNCT2_MUL) begin
      check("mul_valid", 64'(bus.result_valid), 64'd1);
      check("mul_result", 64'(bus.mul_result), 64'(m_mul));
    end
    @(negedge clk); #1;
    bus.start = 1'b0;
    #1;
    check($sformatf("after_stall f=%h", f), 64'(bus.stall_req), 64'd0);
    check($sformatf("after_valid f=%h", f), 64'(bus.result_valid), 64'd0);
    check($sformatf("hilo f=%h a=%h b=%h", f, a, b), {bus.hi, bus.lo}, {m_hi, m_lo});
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hffff_ffff;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] codes [12];

  initial begin
    codes = '{FUNCT_MTHI, FUNCT_MTLO, FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
              FUNCT2_MADD, FUNCT2_MADDU, FUNCT2_MUL, FUNCT2_MSUB, FUNCT2_MSUBU, FUNCT_ADD};
    rst = 1'b0; bus.flush = 1'b0; bus.start = 1'b0;
    bus.funct = 6'd0; bus.op_a = 32'd0; bus.op_b = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_mulres", 64'(bus.mul_result), 64'd0);
    check("reset_valid", 64'(bus.result_valid), 64'd0);
    bus.start = 1'b1; bus.funct = FUNCT_DIV; #1;
    check("reset_stall", 64'(bus.stall_req), 64'd0);
    bus.start = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;

    run_op(FUNCT_MULT,  32'hffff_ffff, 32'd2);
    run_op(FUNCT_MULTU, 32'hffff_ffff, 32'd2);
    run_op(FUNCT_MTHI,  32'd1, 32'd0);
    run_op(FUNCT_MTLO,  32'd0, 32'd0);
    run_op(FUNCT2_MADDU, 32'hffff_ffff, 32'hffff_ffff);
    run_op(FUNCT2_MSUB, 32'd1, 32'd1);
    run_op(FUNCT_DIV,   32'hffff_fff9, 32'd2);
    run_op(FUNCT_DIV,   32'h8000_0000, 32'hffff_ffff);
    run_op(FUNCT_DIVU,  32'd5, 32'd0);
    run_op(FUNCT2_MUL,  32'h0001_0000, 32'h0001_0000);
    run_op(FUNCT2_MUL,  32'hffff_fffd, 32'd7);
    run_op(FUNCT_ADD,   32'h1234_5678, 32'd9);

    // Flush during divider iteration 10.
    bus.start = 1'b1; bus.funct = FUNCT_DIV; bus.op_a = 32'd100; bus.op_b = 32'd7;
    repeat (11) begin @(negedge clk); #1; end
    bus.flush = 1'b1; #1;
    check("flush_stall_now", 64'(bus.stall_req), 64'd0);
    @(negedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0; #1;
    check("flush_stall_next", 64'(bus.stall_req), 64'd0);
    check("flush_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

    // Flush wins over a simultaneous start.
    bus.flush = 1'b1; bus.start = 1'b1; bus.funct = FUNCT_MTHI; bus.op_a = 32'hdead_beef;
    @(negedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0; #1;
    check("flush_start_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
    run_op(FUNCT_MULT, 32'd12345, 32'hffff_fff0);

    // Reset while a MADD is in its accumulate cycle.
    bus.start = 1'b1; bus.funct = FUNCT2_MADD; bus.op_a = 32'd3; bus.op_b = 32'd4;
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    bus.start = 1'b0; #1;
    check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_mid_mulres", 64'(bus.mul_result), 64'd0);
    check("rst_mid_valid", 64'(bus.result_valid), 64'd0);
    check("rst_mid_stall", 64'(bus.stall_req), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0; m_mul = 32'd0;
    rst = 1'b1;

    for (int i = 0; i < 40; i++) begin
      run_op(codes[$urandom_range(0, 11)], rnd_operand(), rnd_operand());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
